lbm_dist_gather9: RTL and testbench

// Upstream feeder for the 9-input fixed-point density adder in the D2Q9 LBM datapath.

---
 rtl/lbm_dist_gather9_if.sv | 33 +++
 rtl/lbm_dist_gather9.sv | 131 +++++++++++++
 tb/tb_lbm_dist_gather9.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/lbm_dist_gather9_if.sv
// Stream-in / node-out bus for the D2Q9 distribution gatherer.
// The slave side is the gatherer; the master side feeds beats and consumes nodes.
interface lbm_dist_gather9_if #(
   parameter int DATA_WIDTH = 64
);
   logic                         s_valid;
   logic                         s_ready;
   logic [3:0]                   s_dir;
   logic signed [DATA_WIDTH-1:0] s_data;
   logic                         m_valid;
   logic                         m_ready;
   logic signed [DATA_WIDTH-1:0] Dout0;
   logic signed [DATA_WIDTH-1:0] Dout1;
   logic signed [DATA_WIDTH-1:0] Dout2;
   logic signed [DATA_WIDTH-1:0] Dout3;
   logic signed [DATA_WIDTH-1:0] Dout4;
   logic signed [DATA_WIDTH-1:0] Dout5;
   logic signed [DATA_WIDTH-1:0] Dout6;
   logic signed [DATA_WIDTH-1:0] Dout7;
   logic signed [DATA_WIDTH-1:0] Dout8;

   modport slave (
      input  s_valid, s_dir, s_data, m_ready,
      output s_ready, m_valid,
      output Dout0, Dout1, Dout2, Dout3, Dout4, Dout5, Dout6, Dout7, Dout8
   );

   modport master (
      output s_valid, s_dir, s_data, m_ready,
      input  s_ready, m_valid,
      input  Dout0, Dout1, Dout2, Dout3, Dout4, Dout5, Dout6, Dout7, Dout8
   );
endinterface

// File: rtl/lbm_dist_gather9.sv
// Serial-to-parallel gatherer for f0..f8 of one lattice node, feeding the
// 9-input density adder. One assembly buffer plus one output register, so the
// next node is collected while the current one waits for the downstream stage.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   COLLECT | accepting beats into the assembly buffer (s_ready=1)
//   FULL    | buffer holds a complete node, output register busy (s_ready=0)
module lbm_dist_gather9 #(
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   lbm_dist_gather9_if.slave    bus,
   output logic [CNT_WIDTH-1:0] node_count,
   output logic                 err_dir
);

   typedef enum logic {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } state_t;

   state_t                state, state_nxt;
   logic [3:0]            idx;
   logic [DATA_WIDTH-1:0] asm_buf [0:8];
   logic [DATA_WIDTH-1:0] dout_q  [0:8];
   logic                  m_valid_q;

   logic beat;
   logic out_xfer;
   logic dir_match;
   logic last_beat;
   logic out_free;

   assign bus.s_ready = (state == COLLECT);
   assign bus.m_valid = m_valid_q;
   assign beat        = bus.s_valid & bus.s_ready;
   assign out_xfer    = m_valid_q & bus.m_ready;
   assign dir_match   = (bus.s_dir == idx);
   assign last_beat   = beat & dir_match & (idx == 4'd8);
   // The 9th beat may bypass straight into the output register if it is empty or draining now.
   assign out_free    = ~m_valid_q | bus.m_ready;

   assign bus.Dout0 = dout_q[0];
   assign bus.Dout1 = dout_q[1];
   assign bus.Dout2 = dout_q[2];
   assign bus.Dout3 = dout_q[3];
   assign bus.Dout4 = dout_q[4];
   assign bus.Dout5 = dout_q[5];
   assign bus.Dout6 = dout_q[6];
   assign bus.Dout7 = dout_q[7];
   assign bus.Dout8 = dout_q[8];

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= COLLECT;
      else       state <= state_nxt;
   end

   // Next-state decode: park in FULL only when a node completes behind a busy output.
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = COLLECT;
      end else begin
         case (state)
            COLLECT: if (last_beat && !out_free) state_nxt = FULL;
            FULL:    if (out_xfer)               state_nxt = COLLECT;
            default:                             state_nxt = COLLECT;
         endcase
      end
   end

   // Assembly buffer, output register, direction tracking, node counter and error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 9; i++) begin
            asm_buf[i] <= '0;
            dout_q[i]  <= '0;
         end
         idx        <= '0;
         m_valid_q  <= 1'b0;
         node_count <= '0;
         err_dir    <= 1'b0;
      end else if (clear) begin
         idx       <= '0;
         m_valid_q <= 1'b0;
         err_dir   <= 1'b0;
      end else begin
         if (out_xfer) node_count <= node_count + 1'b1;
         if (state == FULL) begin
            // Buffered node replaces the one leaving; m_valid stays high.
            if (out_xfer) begin
               for (int i = 0; i < 9; i++) dout_q[i] <= asm_buf[i];
            end
         end else begin
            if (out_xfer) m_valid_q <= 1'b0;
            if (beat) begin
               if (dir_match) begin
                  if (idx != 4'd8) begin
                     asm_buf[idx] <= bus.s_data;
                     idx          <= idx + 4'd1;
                  end else begin
                     idx <= '0;
                     if (out_free) begin
                        for (int i = 0; i < 8; i++) dout_q[i] <= asm_buf[i];
                        dout_q[8] <= bus.s_data;
                        m_valid_q <= 1'b1;
                     end else begin
                        asm_buf[8] <= bus.s_data;
                     end
                  end
               end else begin
                  // Out-of-order beat: drop the partial node; a direction-0 beat restarts one.
                  err_dir <= 1'b1;
                  if (bus.s_dir == 4'd0) begin
                     asm_buf[0] <= bus.s_data;
                     idx        <= 4'd1;
                  end else begin
                     idx <= '0;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_lbm_dist_gather9.sv
// Bench for lbm_dist_gather9: directed node scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_lbm_dist_gather9;

   localparam int DW = 64;
   localparam int CW = 4;

   typedef logic [8:0][DW-1:0] node_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          clear;
   logic [CW-1:0] node_count;
   logic          err_dir;

   lbm_dist_gather9_if #(.DATA_WIDTH(DW)) bus ();

   lbm_dist_gather9 #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .bus        (bus),
      .node_count (node_count),
      .err_dir    (err_dir)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: partial node as a list of values, completed nodes as a queue
   // whose head is what the output should show (capacity two: output + buffer).
   logic [DW-1:0] part_q  [$];
   node_t         nodes_q [$];
   node_t         shown;
   int            m_count;
   bit            m_err;

   task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else             n_pass++;
   endtask

   function automatic void model_reset();
      part_q.delete();
      nodes_q.delete();
      shown   = '0;
      m_count = 0;
      m_err   = 1'b0;
   endfunction

   function automatic void model_step(input logic v, input logic [3:0] d, input logic [DW-1:0] dat,
                                      input logic mr, input logic clr);
      bit    ready;
      node_t n;
      if (clr) begin
         part_q.delete();
         nodes_q.delete();
         m_err = 1'b0;
         return;
      end
      ready = (nodes_q.size() < 2);
      if (nodes_q.size() > 0 && mr) begin
         void'(nodes_q.pop_front());
         m_count++;
      end
      if (v && ready) begin
         if (int'(d) == part_q.size()) begin
            part_q.push_back(dat);
            if (part_q.size() == 9) begin
               for (int i = 0; i < 9; i++) n[i] = part_q[i];
               nodes_q.push_back(n);
               part_q.delete();
            end
         end else begin
            m_err = 1'b1;
            part_q.delete();
            if (d == 4'd0) part_q.push_back(dat);
         end
      end
      if (nodes_q.size() > 0) shown = nodes_q[0];
   endfunction

   task automatic check_outputs();
      logic [DW-1:0] obs [9];
      obs[0] = bus.Dout0; obs[1] = bus.Dout1; obs[2] = bus.Dout2;
      obs[3] = bus.Dout3; obs[4] = bus.Dout4; obs[5] = bus.Dout5;
      obs[6] = bus.Dout6; obs[7] = bus.Dout7; obs[8] = bus.Dout8;
      check_val("m_valid", DW'(bus.m_valid), DW'(nodes_q.size() > 0));
      check_val("s_ready", DW'(bus.s_ready), DW'(nodes_q.size() < 2));
      check_val("err_dir", DW'(err_dir), DW'(m_err));
      check_val("node_count", DW'(node_count), DW'(m_count & ((1 << CW) - 1)));
      for (int k = 0; k < 9; k++) check_val($sformatf("dout%0d", k), obs[k], shown[k]);
   endtask

   task automatic check_sum(input string tag, input logic [DW-1:0] exp);
      logic signed [DW-1:0] s;
      s = $signed(bus.Dout0) + $signed(bus.Dout1) + $signed(bus.Dout2) + $signed(bus.Dout3)
        + $signed(bus.Dout4) + $signed(bus.Dout5) + $signed(bus.Dout6) + $signed(bus.Dout7)
        + $signed(bus.Dout8);
      check_val(tag, s, exp);
   endtask

   // One clock: inputs applied at the falling edge, model advanced at the rising edge,
   // outputs checked at the next falling edge.
   task automatic drive(input logic v, input logic [3:0] d, input logic [DW-1:0] dat,
                        input logic mr, input logic clr);
      bus.s_valid = v;
      bus.s_dir   = d;
      bus.s_data  = dat;
      bus.m_ready = mr;
      clear       = clr;
      @(posedge clk);
      model_step(v, d, dat, mr, clr);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #1;
      model_reset();
      check_outputs();
      bus.s_valid = 1'b0;
      @(negedge clk);
      check_outputs();
      reset = 1'b0;
   endtask

   task automatic send_node(input node_t n, input logic mr);
      for (int k = 0; k < 9; k++) drive(1'b1, 4'(k), n[k], mr, 1'b0);
   endtask

   task automatic idle(input int cycles, input logic mr);
      for (int i = 0; i < cycles; i++) drive(1'b0, 4'd0, '0, mr, 1'b0);
   endtask

   node_t nd_a, nd_b, nd_neg;
   logic [DW-1:0] rnd;
   logic [3:0]    rdir;
   logic          rmr;
   bit            stall_mode;

   initial begin
      reset       = 1'b1;
      clear       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_dir   = '0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;
      model_reset();
      @(negedge clk);
      check_outputs();
      reset = 1'b0;

      // f0..f8 = 1..9 in Q8.56, streamed back-to-back with downstream ready.
      for (int k = 0; k < 9; k++) begin
         nd_a[k] = {8'(k + 1), 56'd0};
         nd_b[k] = {8'(k + 10), 56'd0};
         nd_neg[k] = {8'(k + 1), 56'd0};
      end
      nd_neg[8] = 64'hF700_0000_0000_0000;
      nd_neg[4] = 64'hFEFE_8000_0000_0000;
      send_node(nd_a, 1'b1);
      check_sum("sum45", {8'd45, 56'd0});
      idle(2, 1'b1);

      // Two nodes against a stalled consumer, then release.
      send_node(nd_a, 1'b0);
      send_node(nd_b, 1'b0);
      idle(5, 1'b0);
      idle(4, 1'b1);

      // Negative values must pass bit-exact.
      nd_neg[4] = {8'd5, 56'd0};
      send_node(nd_neg, 1'b0);
      check_sum("sum27", {8'd27, 56'd0});
      idle(1, 1'b1);
      nd_neg[4] = 64'hFEFE_8000_0000_0000;
      send_node(nd_neg, 1'b1);
      idle(1, 1'b1);

      // Out-of-order directions, clean recovery, and restart on a fresh direction 0.
      drive(1'b1, 4'd0, 64'h11, 1'b1, 1'b0);
      drive(1'b1, 4'd1, 64'h22, 1'b1, 1'b0);
      drive(1'b1, 4'd2, 64'h33, 1'b1, 1'b0);
      drive(1'b1, 4'd5, 64'h44, 1'b1, 1'b0);
      drive(1'b1, 4'd12, 64'h55, 1'b1, 1'b0);
      send_node(nd_b, 1'b1);
      drive(1'b1, 4'd0, 64'h66, 1'b1, 1'b0);
      drive(1'b1, 4'd1, 64'h77, 1'b1, 1'b0);
      send_node(nd_a, 1'b1);
      idle(1, 1'b1);

      // Reset during beat 4, then a clean node.
      for (int k = 0; k < 4; k++) drive(1'b1, 4'(k), nd_b[k], 1'b1, 1'b0);
      apply_reset();
      send_node(nd_a, 1'b1);
      idle(1, 1'b1);

      // Reset while a node is held against a stalled consumer.
      send_node(nd_b, 1'b0);
      idle(2, 1'b0);
      apply_reset();
      send_node(nd_b, 1'b1);
      idle(1, 1'b1);

      // Clear in the middle of a node with an error pending.
      drive(1'b1, 4'd3, 64'h99, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) drive(1'b1, 4'(k), nd_a[k], 1'b0, 1'b0);
      drive(1'b0, 4'd0, '0, 1'b0, 1'b1);
      send_node(nd_b, 1'b1);
      idle(1, 1'b1);

      // Randomized traffic: mostly in-order beats, occasional bad directions, stalls and clears.
      stall_mode = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if ((c % 64) == 0) stall_mode = ($urandom_range(0, 2) == 0);
         rnd  = {$urandom, $urandom};
         rdir = ($urandom_range(0, 24) == 0) ? 4'($urandom_range(0, 15)) : 4'(part_q.size());
         rmr  = stall_mode ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
         drive($urandom_range(0, 3) != 0, rdir, rnd, rmr, $urandom_range(0, 299) == 0);
      end
      idle(4, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
